// File: rtl/multi_stream_activation_write_control.sv
// -----------------------------------------------------------------------------
// multi_stream_activation_write_control
//
// Purpose:
//   AXI-Stream ingress that splits one input stream by TID.
//     TID 0                -> weight memory (combinational pass-through)
//     TID 1..NUM_STREAMS   -> activation line buffers through a registered
//                             bank write port
//     any other TID        -> dropped, err_bad_tid set
//   The route, target line buffer and bank mode are latched on the first
//   accepted beat of a packet and held until the accepted tlast beat.
//
// Optional feature (compile-time macro ACT_WRITE_PTR_AUTO_INC_EN):
//   defined   : a packet that completes in ACT advances its stream pointer
//               to the next line buffer (mod NUM_LINE_BUFFERS)
//   undefined : stream pointers change only on cfg_stream_ptr_load or reset
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   cfg_mode                 0 serial (one bank per beat), 1 parallel (all banks)
//   cfg_stream_ptr_load      load all stream pointers from cfg_stream_base_ptr
//   cfg_stream_base_ptr      per-stream initial line-buffer pointer
//   err_clear                clears the sticky error flags
//   s_axis_*                 input stream (tdata/tvalid/tready/tlast/tid)
//   lb_ready                 per-bank accept capability, index lb*BANK_COUNT+bank
//   wr_data/wr_addr/wr_wen   registered line-buffer write port
//   wr_port_enable           registered, high with any wr_wen bit
//   wm_*                     weight memory stream
//   stream_ptr               current line-buffer pointer per stream
//   busy                     FSM not idle
//   err_bad_tid/err_overflow sticky error flags
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | between packets; route decoded live from s_axis_tid
//   ST_WEIGHT | weight packet in progress, pass-through to wm_*
//   ST_ACT    | activation packet in progress, writing line buffer
//   ST_DROP   | bad TID or overflowed packet, beats discarded until tlast
// -----------------------------------------------------------------------------
module multi_stream_activation_write_control #(
  parameter  int DATA_WIDTH        = 64,
  parameter  int BANK_COUNT        = 4,
  parameter  int LINE_BUFFER_DEPTH = 512,
  parameter  int NUM_LINE_BUFFERS  = 8,
  parameter  int NUM_STREAMS       = 3,
  parameter  int TID_WIDTH         = 4,
  localparam int ADDR_W = (LINE_BUFFER_DEPTH > 1) ? $clog2(LINE_BUFFER_DEPTH) : 1,
  localparam int SEL_W  = (NUM_LINE_BUFFERS > 1)  ? $clog2(NUM_LINE_BUFFERS)  : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_mode,
  input  logic                                 cfg_stream_ptr_load,
  input  logic [NUM_STREAMS*SEL_W-1:0]         cfg_stream_base_ptr,
  input  logic                                 err_clear,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic [TID_WIDTH-1:0]                 s_axis_tid,
  input  logic [NUM_LINE_BUFFERS*BANK_COUNT-1:0] lb_ready,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic [ADDR_W-1:0]                    wr_addr,
  output logic [NUM_LINE_BUFFERS*BANK_COUNT-1:0] wr_wen,
  output logic                                 wr_port_enable,
  output logic [DATA_WIDTH-1:0]                wm_tdata,
  output logic                                 wm_tvalid,
  output logic                                 wm_tlast,
  input  logic                                 wm_tready,
  output logic [NUM_STREAMS*SEL_W-1:0]         stream_ptr,
  output logic                                 busy,
  output logic                                 err_bad_tid,
  output logic                                 err_overflow
);

  localparam int BANK_W = (BANK_COUNT > 1)  ? $clog2(BANK_COUNT)  : 1;
  localparam int STR_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  localparam logic [TID_WIDTH-1:0] TID_MAX   = TID_WIDTH'(NUM_STREAMS);
  localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(LINE_BUFFER_DEPTH - 1);
  localparam logic [BANK_W-1:0]    BANK_LAST = BANK_W'(BANK_COUNT - 1);
  localparam logic [SEL_W-1:0]     SEL_LAST  = SEL_W'(NUM_LINE_BUFFERS - 1);

`ifdef ACT_WRITE_PTR_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WEIGHT = 2'd1,
    ST_ACT    = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // 2-D views of the flat bank vectors: [line buffer][bank]
  logic [NUM_LINE_BUFFERS-1:0][BANK_COUNT-1:0] lb_rdy;
  logic [NUM_LINE_BUFFERS-1:0][BANK_COUNT-1:0] wr_wen_q, wr_wen_d;

  logic [NUM_STREAMS-1:0][SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0]      lb_q, lb_d;
  logic [STR_W-1:0]      sidx_q, sidx_d;
  logic                  mode_q, mode_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  wr_port_en_q, wr_port_en_d;
  logic                  err_bad_q, err_bad_d;
  logic                  err_ovf_q, err_ovf_d;

  // live TID decode, only meaningful in ST_IDLE
  logic             tid_is_weight;
  logic             tid_is_act;
  logic [STR_W-1:0] tid_sidx;

  // packet context: live decode in IDLE, latched values otherwise
  logic             route_weight;
  logic             route_act;
  logic [SEL_W-1:0] cur_lb;
  logic [STR_W-1:0] cur_sidx;
  logic             cur_mode;

  logic act_rdy;
  logic accept;
  logic act_beat;
  logic addr_adv;
  logic ovf_evt;
  logic bad_evt;

  assign lb_rdy = lb_ready;

  assign tid_is_weight = (s_axis_tid == '0);
  assign tid_is_act    = (s_axis_tid != '0) && (s_axis_tid <= TID_MAX);
  assign tid_sidx      = STR_W'(s_axis_tid - 1'b1);

  always_comb begin
    route_weight = 1'b0;
    route_act    = 1'b0;
    cur_lb       = lb_q;
    cur_sidx     = sidx_q;
    cur_mode     = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        route_weight = tid_is_weight;
        route_act    = tid_is_act;
        cur_lb       = ptr_q[tid_sidx];
        cur_sidx     = tid_sidx;
        cur_mode     = cfg_mode;
      end
      ST_WEIGHT: route_weight = 1'b1;
      ST_ACT:    route_act    = 1'b1;
      default:   ;
    endcase
  end

  // bank_q is always 0 in IDLE, so the serial check picks bank 0 of the
  // new packet's buffer without special casing
  assign act_rdy = cur_mode ? (&lb_rdy[cur_lb]) : lb_rdy[cur_lb][bank_q];

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign act_beat = accept && route_act;
  assign addr_adv = cur_mode || (bank_q == BANK_LAST);
  assign ovf_evt  = act_beat && !s_axis_tlast && addr_adv && (addr_q == ADDR_LAST);
  assign bad_evt  = accept && (state_q == ST_IDLE) && !tid_is_weight && !tid_is_act;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !s_axis_tlast) begin
          if (tid_is_weight)   state_d = ST_WEIGHT;
          else if (tid_is_act) state_d = ovf_evt ? ST_DROP : ST_ACT;
          else                 state_d = ST_DROP;
        end
      end
      ST_WEIGHT: if (accept && s_axis_tlast) state_d = ST_IDLE;
      ST_ACT: begin
        if (accept && s_axis_tlast) state_d = ST_IDLE;
        else if (ovf_evt)           state_d = ST_DROP;
      end
      ST_DROP: if (accept && s_axis_tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (tready never looks at tvalid)
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axis_tready = 1'b1;
    if (route_weight)   s_axis_tready = wm_tready;
    else if (route_act) s_axis_tready = act_rdy;
    wm_tvalid = route_weight && s_axis_tvalid;
    busy      = (state_q != ST_IDLE);
  end

  assign wm_tdata = s_axis_tdata;
  assign wm_tlast = s_axis_tlast;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    lb_d         = lb_q;
    sidx_d       = sidx_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    bank_d       = bank_q;
    wr_wen_d     = '0;
    wr_port_en_d = 1'b0;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;

    if (accept && (state_q == ST_IDLE)) begin
      lb_d   = cur_lb;
      sidx_d = cur_sidx;
      mode_d = cur_mode;
    end

    if (act_beat) begin
      if (cur_mode) wr_wen_d[cur_lb]         = '1;
      else          wr_wen_d[cur_lb][bank_q] = 1'b1;
      wr_port_en_d = 1'b1;
      wr_data_d    = s_axis_tdata;
      wr_addr_d    = addr_q;
    end

    // the address saturates at the last word; an overflow hands over to
    // DROP, which holds it until the packet's tlast clears it
    if (accept && s_axis_tlast) begin
      addr_d = '0;
      bank_d = '0;
    end else if (act_beat) begin
      if (!cur_mode) bank_d = (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;
      if (addr_adv && (addr_q != ADDR_LAST)) addr_d = addr_q + 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (cfg_stream_ptr_load) begin
      ptr_d = cfg_stream_base_ptr;
    end else if (AUTO_INC && act_beat && s_axis_tlast) begin
      ptr_d[cur_sidx] = (ptr_q[cur_sidx] == SEL_LAST) ? '0 : ptr_q[cur_sidx] + 1'b1;
    end
  end

  // a same-cycle error event wins over err_clear
  assign err_bad_d = (err_bad_q && !err_clear) || bad_evt;
  assign err_ovf_d = (err_ovf_q && !err_clear) || ovf_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      lb_q         <= '0;
      sidx_q       <= '0;
      mode_q       <= 1'b0;
      addr_q       <= '0;
      bank_q       <= '0;
      ptr_q        <= '0;
      wr_wen_q     <= '0;
      wr_port_en_q <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      err_bad_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      lb_q         <= lb_d;
      sidx_q       <= sidx_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      bank_q       <= bank_d;
      ptr_q        <= ptr_d;
      wr_wen_q     <= wr_wen_d;
      wr_port_en_q <= wr_port_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      err_bad_q    <= err_bad_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign wr_wen         = wr_wen_q;
  assign wr_port_enable = wr_port_en_q;
  assign wr_data        = wr_data_q;
  assign wr_addr        = wr_addr_q;
  assign stream_ptr     = ptr_q;
  assign err_bad_tid    = err_bad_q;
  assign err_overflow   = err_ovf_q;

endmodule

// File: tb/tb_multi_stream_activation_write_control.sv
module tb_multi_stream_activation_write_control;

  localparam int DW    = 64;
  localparam int BC    = 4;
  localparam int DEPTH = 4;
  localparam int NLB   = 8;
  localparam int NS    = 3;
  localparam int TW    = 4;
  localparam int SELW  = 3;
  localparam int AW    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_mode;
  logic                cfg_stream_ptr_load;
  logic [NS*SELW-1:0]  cfg_stream_base_ptr;
  logic                err_clear;
  logic [DW-1:0]       s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                s_axis_tlast;
  logic [TW-1:0]       s_axis_tid;
  logic [NLB*BC-1:0]   lb_ready;
  logic [DW-1:0]       wr_data;
  logic [AW-1:0]       wr_addr;
  logic [NLB*BC-1:0]   wr_wen;
  logic                wr_port_enable;
  logic [DW-1:0]       wm_tdata;
  logic                wm_tvalid;
  logic                wm_tlast;
  logic                wm_tready;
  logic [NS*SELW-1:0]  stream_ptr;
  logic                busy;
  logic                err_bad_tid;
  logic                err_overflow;

  multi_stream_activation_write_control #(
    .DATA_WIDTH(DW), .BANK_COUNT(BC), .LINE_BUFFER_DEPTH(DEPTH),
    .NUM_LINE_BUFFERS(NLB), .NUM_STREAMS(NS), .TID_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode),
    .cfg_stream_ptr_load(cfg_stream_ptr_load), .cfg_stream_base_ptr(cfg_stream_base_ptr),
    .err_clear(err_clear), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .lb_ready(lb_ready), .wr_data(wr_data), .wr_addr(wr_addr), .wr_wen(wr_wen),
    .wr_port_enable(wr_port_enable), .wm_tdata(wm_tdata), .wm_tvalid(wm_tvalid),
    .wm_tlast(wm_tlast), .wm_tready(wm_tready), .stream_ptr(stream_ptr), .busy(busy),
    .err_bad_tid(err_bad_tid), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]     tid;
    logic              mode;
    logic [DW-1:0]     data;
    logic              last;
    logic [NLB*BC-1:0] exp_wen;
    logic [AW-1:0]     exp_addr;
    logic              exp_busy;
  } vec_t;

  typedef struct {
    logic [NLB*BC-1:0] wen;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
  } wr_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } wm_t;

  vec_t vecs [12];
  wr_t  wq   [$];
  wm_t  wmq  [$];

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [NS*SELW-1:0] BASE = {3'd5, 3'd7, 3'd2};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ptrs(input logic [NS*SELW-1:0] v);
    cfg_stream_base_ptr = v;
    cfg_stream_ptr_load = 1'b1;
    tick();
    cfg_stream_ptr_load = 1'b0;
  endtask

  // presents one beat and holds it until accepted (bounded)
  task automatic send(input logic [TW-1:0] tid, input logic [DW-1:0] data,
                      input logic last, input string name);
    bit ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tid    = tid;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_accept_timeout"}, 64'(0), 64'(1));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // write-port and weight-stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_wen != '0) wq.push_back('{wr_wen, wr_addr, wr_data});
    if (wr_port_enable || (wr_wen != '0))
      chk("port_enable", 64'(wr_port_enable), 64'(wr_wen != '0));
    if (wm_tvalid && wm_tready) wmq.push_back('{wm_tdata, wm_tlast});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NS*SELW-1:0] exp_ptr;
    logic [NLB*BC-1:0]  exp_w0, exp_w1;

    // serial, tid 1 -> lb 2: banks 0..3 repeat, address steps on bank wrap
    vecs[0]  = '{4'd1, 1'b0, 64'h1000, 1'b0, 32'h0000_0100, 2'd0, 1'b1};
    vecs[1]  = '{4'd1, 1'b0, 64'h1001, 1'b0, 32'h0000_0200, 2'd0, 1'b1};
    vecs[2]  = '{4'd1, 1'b0, 64'h1002, 1'b0, 32'h0000_0400, 2'd0, 1'b1};
    vecs[3]  = '{4'd1, 1'b0, 64'h1003, 1'b0, 32'h0000_0800, 2'd0, 1'b1};
    vecs[4]  = '{4'd1, 1'b0, 64'h1004, 1'b0, 32'h0000_0100, 2'd1, 1'b1};
    vecs[5]  = '{4'd1, 1'b0, 64'h1005, 1'b0, 32'h0000_0200, 2'd1, 1'b1};
    vecs[6]  = '{4'd1, 1'b0, 64'h1006, 1'b0, 32'h0000_0400, 2'd1, 1'b1};
    vecs[7]  = '{4'd1, 1'b0, 64'h1007, 1'b0, 32'h0000_0800, 2'd1, 1'b1};
    vecs[8]  = '{4'd1, 1'b0, 64'h1008, 1'b1, 32'h0000_0100, 2'd2, 1'b0};
    // parallel, tid 3 -> lb 5: all four banks each beat
    vecs[9]  = '{4'd3, 1'b1, 64'h2000, 1'b0, 32'h00F0_0000, 2'd0, 1'b1};
    vecs[10] = '{4'd3, 1'b1, 64'h2001, 1'b0, 32'h00F0_0000, 2'd1, 1'b1};
    vecs[11] = '{4'd3, 1'b1, 64'h2002, 1'b1, 32'h00F0_0000, 2'd2, 1'b0};

    reset = 1'b1; cfg_mode = 1'b0; cfg_stream_ptr_load = 1'b0; cfg_stream_base_ptr = '0;
    err_clear = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; lb_ready = '1; wm_tready = 1'b0;
    repeat (3) tick();

    chk("rst_wr_wen",   64'(wr_wen), 64'(0));
    chk("rst_wr_addr",  64'(wr_addr), 64'(0));
    chk("rst_wr_data",  64'(wr_data), 64'(0));
    chk("rst_port_en",  64'(wr_port_enable), 64'(0));
    chk("rst_busy",     64'(busy), 64'(0));
    chk("rst_err_bad",  64'(err_bad_tid), 64'(0));
    chk("rst_err_ovf",  64'(err_overflow), 64'(0));
    chk("rst_ptr",      64'(stream_ptr), 64'(0));
    chk("rst_wm_valid", 64'(wm_tvalid), 64'(0));
    reset = 1'b0;
    tick();

    load_ptrs(BASE);
    chk("ptr_load", 64'(stream_ptr), 64'(BASE));

    // ---- table: serial 9-beat packet then parallel 3-beat packet ----
    wq.delete(); wmq.delete();
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tid    = vecs[i].tid;
      cfg_mode      = vecs[i].mode;
      s_axis_tdata  = vecs[i].data;
      s_axis_tlast  = vecs[i].last;
      #1;
      chk("tbl_tready", 64'(s_axis_tready), 64'(1));
      @(posedge clk);
      #1;
      chk("tbl_wen",  64'(wr_wen),  64'(vecs[i].exp_wen));
      chk("tbl_addr", 64'(wr_addr), 64'(vecs[i].exp_addr));
      chk("tbl_data", 64'(wr_data), 64'(vecs[i].data));
      chk("tbl_busy", 64'(busy),    64'(vecs[i].exp_busy));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    tick();
    chk("tbl_wen_idle", 64'(wr_wen), 64'(0));
    chk("tbl_busy_end", 64'(busy), 64'(0));
    chk("tbl_no_wm",    64'(wmq.size()), 64'(0));
`ifdef ACT_WRITE_PTR_AUTO_INC_EN
    exp_ptr = {3'd6, 3'd7, 3'd3};
`else
    exp_ptr = BASE;
`endif
    chk("tbl_ptr_after", 64'(stream_ptr), 64'(exp_ptr));

    // ---- parallel stall: bank 1 of lb 5 not ready for 2 cycles ----
    load_ptrs(BASE);
    wq.delete();
    cfg_mode = 1'b1;
    lb_ready[21] = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tid = 4'd3; s_axis_tdata = 64'h3000; s_axis_tlast = 1'b0;
    #1;
    chk("stall_tready_c0", 64'(s_axis_tready), 64'(0));
    tick();
    chk("stall_tready_c1", 64'(s_axis_tready), 64'(0));
    chk("stall_no_write",  64'(wr_wen), 64'(0));
    tick();
    chk("stall_tready_c2", 64'(s_axis_tready), 64'(0));
    lb_ready[21] = 1'b1;
    #1;
    chk("stall_release", 64'(s_axis_tready), 64'(1));
    send(4'd3, 64'h3000, 1'b0, "stall_b0");
    send(4'd3, 64'h3001, 1'b0, "stall_b1");
    send(4'd3, 64'h3002, 1'b1, "stall_b2");
    tick();
    chk("stall_nwrites", 64'(wq.size()), 64'(3));
    if (wq.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("stall_wen",  64'(wq[k].wen),  64'(32'h00F0_0000));
        chk("stall_addr", 64'(wq[k].addr), 64'(k));
        chk("stall_data", 64'(wq[k].data), 64'h3000 + 64'(k));
      end
    end

    // ---- weight path with wm_tready back-pressure and mid-packet TID change ----
    wq.delete(); wmq.delete();
    wm_tready = 1'b1;
    send(4'd0, 64'hA0, 1'b0, "wm_b0");
    wm_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tid = 4'd0; s_axis_tdata = 64'hA1; s_axis_tlast = 1'b0;
    #1;
    chk("wm_tready_low", 64'(s_axis_tready), 64'(0));
    chk("wm_valid_high", 64'(wm_tvalid), 64'(1));
    chk("wm_data_pass",  64'(wm_tdata), 64'hA1);
    repeat (3) begin
      tick();
      chk("wm_tready_hold", 64'(s_axis_tready), 64'(0));
    end
    wm_tready = 1'b1;
    #1;
    chk("wm_tready_high", 64'(s_axis_tready), 64'(1));
    send(4'd0, 64'hA1, 1'b0, "wm_b1");
    send(4'd1, 64'hA2, 1'b0, "wm_b2");
    send(4'd0, 64'hA3, 1'b1, "wm_b3");
    tick();
    chk("wm_nbeats", 64'(wmq.size()), 64'(4));
    if (wmq.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("wm_data", 64'(wmq[k].data), 64'hA0 + 64'(k));
        chk("wm_last", 64'(wmq[k].last), 64'(k == 3));
      end
    end
    chk("wm_no_writes", 64'(wq.size()), 64'(0));
    chk("wm_busy_end",  64'(busy), 64'(0));

    // ---- overflow: depth 4, serial, 20 beats ----
    load_ptrs(BASE);
    wq.delete();
    cfg_mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send(4'd1, 64'h4000 + 64'(k), 1'b0, "ovf_wr");
      if (k == 14) chk("ovf_not_yet", 64'(err_overflow), 64'(0));
      if (k == 15) begin
        chk("ovf_set",  64'(err_overflow), 64'(1));
        chk("ovf_busy", 64'(busy), 64'(1));
      end
    end
    lb_ready = '0;
    for (int k = 16; k < 20; k++) begin
      s_axis_tvalid = 1'b1; s_axis_tid = 4'd1; s_axis_tlast = (k == 19);
      #1;
      chk("ovf_drop_tready", 64'(s_axis_tready), 64'(1));
      send(4'd1, 64'h4000 + 64'(k), (k == 19), "ovf_drop");
    end
    lb_ready = '1;
    tick();
    chk("ovf_busy_end", 64'(busy), 64'(0));
    chk("ovf_nwrites",  64'(wq.size()), 64'(16));
    if (wq.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk("ovf_wen",  64'(wq[k].wen),  64'(32'h0000_0100 << (k % 4)));
        chk("ovf_addr", 64'(wq[k].addr), 64'(k / 4));
        chk("ovf_data", 64'(wq[k].data), 64'h4000 + 64'(k));
      end
    end
    chk("ovf_ptr_kept", 64'(stream_ptr), 64'(BASE));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovf_cleared", 64'(err_overflow), 64'(0));

    // ---- bad TID, then TID 0 mid-packet still dropped ----
    wq.delete(); wmq.delete();
    send(4'd7, 64'hB0, 1'b0, "bad_b0");
    chk("bad_err_set", 64'(err_bad_tid), 64'(1));
    chk("bad_busy",    64'(busy), 64'(1));
    s_axis_tvalid = 1'b1; s_axis_tid = 4'd0; s_axis_tdata = 64'hB1; s_axis_tlast = 1'b0;
    #1;
    chk("bad_no_wm_valid", 64'(wm_tvalid), 64'(0));
    send(4'd0, 64'hB1, 1'b0, "bad_b1");
    send(4'd0, 64'hB2, 1'b1, "bad_b2");
    chk("bad_idle", 64'(busy), 64'(0));
    tick();
    chk("bad_no_writes", 64'(wq.size()), 64'(0));
    chk("bad_no_wm",     64'(wmq.size()), 64'(0));
    // clear coinciding with a new bad-TID beat keeps the flag
    err_clear = 1'b1;
    send(4'd9, 64'hC0, 1'b1, "bad_single");
    err_clear = 1'b0;
    chk("bad_clear_race", 64'(err_bad_tid), 64'(1));
    chk("bad_single_idle", 64'(busy), 64'(0));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("bad_cleared", 64'(err_bad_tid), 64'(0));
    chk("bad_ovf_quiet", 64'(err_overflow), 64'(0));

    // ---- reset mid-packet ----
    wq.delete();
    cfg_mode = 1'b0;
    send(4'd2, 64'hD0, 1'b0, "rstmid_b0");
    send(4'd2, 64'hD1, 1'b0, "rstmid_b1");
    chk("rstmid_wen_b1", 64'(wr_wen), 64'(32'h2000_0000));
    reset = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tid = 4'd2; s_axis_tdata = 64'hD2;
    tick();
    chk("rstmid_wen",  64'(wr_wen), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_ptr",  64'(stream_ptr), 64'(0));
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rstmid_wen_after", 64'(wr_wen), 64'(0));
    chk("rstmid_nwrites",   64'(wq.size()), 64'(2));

    // ---- stream pointer behaviour over two tid=2 packets from ptr 7 ----
    load_ptrs(BASE);
    wq.delete();
    cfg_mode = 1'b1;
    send(4'd2, 64'hE0, 1'b0, "ptr_p0b0");
    send(4'd2, 64'hE1, 1'b1, "ptr_p0b1");
    send(4'd2, 64'hE2, 1'b0, "ptr_p1b0");
    send(4'd2, 64'hE3, 1'b1, "ptr_p1b1");
    tick();
    exp_w0 = 32'hF000_0000;
`ifdef ACT_WRITE_PTR_AUTO_INC_EN
    exp_w1  = 32'h0000_000F;
    exp_ptr = {3'd5, 3'd1, 3'd2};
`else
    exp_w1  = 32'hF000_0000;
    exp_ptr = BASE;
`endif
    chk("ptr_nwrites", 64'(wq.size()), 64'(4));
    if (wq.size() == 4) begin
      chk("ptr_pkt0_wen",  64'(wq[0].wen),  64'(exp_w0));
      chk("ptr_pkt0_addr", 64'(wq[1].addr), 64'(1));
      chk("ptr_pkt1_wen",  64'(wq[2].wen),  64'(exp_w1));
      chk("ptr_pkt1_addr", 64'(wq[2].addr), 64'(0));
    end
    chk("ptr_final", 64'(stream_ptr), 64'(exp_ptr));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
